// File: rtl/dct_row_loader_pkg.sv
// Shared constants for the DCT row loader: default widths, DCT pacing
// and the issue-FSM state encodings.
package dct_row_loader_pkg;

    localparam int DATA_IN_WIDTH        = 8;
    localparam int DATA_IN_SIGNED_WIDTH = DATA_IN_WIDTH + 1;
    localparam int DCT_BUSY_CYCLES      = 7;
    localparam int ROW_LEN              = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;

endpackage

// File: rtl/dct_row_loader.sv
// Collects 8 pixels into a row buffer, level-shifts them on entry and hands
// complete rows to an 8-point DCT with a one-cycle start pulse. Collection of
// the next row overlaps the DCT busy time (double buffering).
module dct_row_loader #(
    parameter int DATA_IN_WIDTH   = dct_row_loader_pkg::DATA_IN_WIDTH,
    parameter int LEVEL_SHIFT     = 1,
    parameter int DCT_BUSY_CYCLES = dct_row_loader_pkg::DCT_BUSY_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pix_valid,
    input  logic [DATA_IN_WIDTH-1:0] pix_data,
    output logic                     pix_ready,
    output logic                     dct_ena,
    output logic [DATA_IN_WIDTH:0]   dct_data0,
    output logic [DATA_IN_WIDTH:0]   dct_data1,
    output logic [DATA_IN_WIDTH:0]   dct_data2,
    output logic [DATA_IN_WIDTH:0]   dct_data3,
    output logic [DATA_IN_WIDTH:0]   dct_data4,
    output logic [DATA_IN_WIDTH:0]   dct_data5,
    output logic [DATA_IN_WIDTH:0]   dct_data6,
    output logic [DATA_IN_WIDTH:0]   dct_data7,
    output logic [15:0]              rows_issued
);
    import dct_row_loader_pkg::*;

    localparam int SW = DATA_IN_WIDTH + 1;
    // BUSY holds for DCT_BUSY_CYCLES-2 cycles so that ISSUE + BUSY + the IDLE
    // copy cycle put back-to-back start pulses exactly DCT_BUSY_CYCLES apart.
    localparam int BUSY_LOAD = (DCT_BUSY_CYCLES > 2) ? (DCT_BUSY_CYCLES - 2) : 1;
    localparam int CNT_W     = (BUSY_LOAD < 2) ? 1 : $clog2(BUSY_LOAD + 1);
    localparam logic [SW-1:0] OFFSET =
        (LEVEL_SHIFT != 0) ? (SW'(1) << (DATA_IN_WIDTH - 1)) : SW'(0);

    logic [1:0]       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             row_full_q, row_full_d;
    logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
    logic [15:0]      rows_issued_q, rows_issued_d;
    logic [SW-1:0]    collect_q [ROW_LEN];
    logic [SW-1:0]    collect_d [ROW_LEN];
    logic [SW-1:0]    dct_data_q [ROW_LEN];
    logic [SW-1:0]    dct_data_d [ROW_LEN];
    logic [SW-1:0]    pix_shifted;
    logic             xfer;
    logic             copy;

    // Unsigned pixel widened by one bit, optionally re-centred around zero;
    // the result always fits so no saturation is needed.
    assign pix_shifted = {1'b0, pix_data} - OFFSET;

    assign pix_ready   = !rst && (!row_full_q || (state_q == ST_IDLE && row_full_q));
    assign xfer        = pix_valid && pix_ready;
    assign copy        = (state_q == ST_IDLE) && row_full_q;
    assign dct_ena     = (state_q == ST_ISSUE);
    assign rows_issued = rows_issued_q;

    assign dct_data0 = dct_data_q[0];
    assign dct_data1 = dct_data_q[1];
    assign dct_data2 = dct_data_q[2];
    assign dct_data3 = dct_data_q[3];
    assign dct_data4 = dct_data_q[4];
    assign dct_data5 = dct_data_q[5];
    assign dct_data6 = dct_data_q[6];
    assign dct_data7 = dct_data_q[7];

    // Next-state: issue FSM, row hand-off copy and pixel collection.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        row_full_d    = row_full_q;
        busy_cnt_d    = busy_cnt_q;
        rows_issued_d = rows_issued_q;
        collect_d     = collect_q;
        dct_data_d    = dct_data_q;

        case (state_q)
            ST_IDLE: begin
                if (copy) begin
                    dct_data_d = collect_q;
                    row_full_d = 1'b0;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d       = ST_BUSY;
                busy_cnt_d    = CNT_W'(BUSY_LOAD);
                rows_issued_d = rows_issued_q + 16'd1;
            end
            ST_BUSY: begin
                if (busy_cnt_q <= CNT_W'(1)) begin
                    busy_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    busy_cnt_d = busy_cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A transfer on the copy edge lands in slot 0 of the next row while
        // the copy reads the old buffer contents, so nothing is lost.
        if (xfer) begin
            collect_d[idx_q] = pix_shifted;
            idx_d            = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
                row_full_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset clearing both row buffers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            row_full_q    <= 1'b0;
            busy_cnt_q    <= '0;
            rows_issued_q <= '0;
            for (int i = 0; i < ROW_LEN; i++) begin
                collect_q[i]  <= '0;
                dct_data_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            row_full_q    <= row_full_d;
            busy_cnt_q    <= busy_cnt_d;
            rows_issued_q <= rows_issued_d;
            collect_q     <= collect_d;
            dct_data_q    <= dct_data_d;
        end
    end

endmodule

// File: tb/tb_dct_row_loader.sv
// Self-checking bench for dct_row_loader: table-driven rows, hand-written
// reset/stall sequences and a randomized run against a pixel-queue model.
module tb_dct_row_loader;

    localparam int W         = 8;
    localparam int BUSY      = 7;
    localparam int SLOW_BUSY = 12;
    localparam int HALF      = 128;
    localparam int NV        = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_valid = 1'b0;
    logic [W-1:0] pix_data = '0;
    logic s_valid = 1'b0;
    logic [W-1:0] s_data = '0;

    logic pix_ready, dct_ena, pix_ready_ns, dct_ena_ns, s_ready, s_ena;
    logic [15:0] rows_issued, rows_issued_ns, s_rows;
    wire [W:0] dd [8];
    wire [W:0] ddn [8];
    wire [W:0] sdd [8];

    always #5 clk = ~clk;

    dct_row_loader #(.DATA_IN_WIDTH(W), .LEVEL_SHIFT(1), .DCT_BUSY_CYCLES(BUSY)) u_dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(pix_ready), .dct_ena(dct_ena),
        .dct_data0(dd[0]), .dct_data1(dd[1]), .dct_data2(dd[2]), .dct_data3(dd[3]),
        .dct_data4(dd[4]), .dct_data5(dd[5]), .dct_data6(dd[6]), .dct_data7(dd[7]),
        .rows_issued(rows_issued)
    );

    dct_row_loader #(.DATA_IN_WIDTH(W), .LEVEL_SHIFT(0), .DCT_BUSY_CYCLES(BUSY)) u_dut_ns (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(pix_ready_ns), .dct_ena(dct_ena_ns),
        .dct_data0(ddn[0]), .dct_data1(ddn[1]), .dct_data2(ddn[2]), .dct_data3(ddn[3]),
        .dct_data4(ddn[4]), .dct_data5(ddn[5]), .dct_data6(ddn[6]), .dct_data7(ddn[7]),
        .rows_issued(rows_issued_ns)
    );

    dct_row_loader #(.DATA_IN_WIDTH(W), .LEVEL_SHIFT(1), .DCT_BUSY_CYCLES(SLOW_BUSY)) u_dut_slow (
        .clk(clk), .rst(rst), .pix_valid(s_valid), .pix_data(s_data),
        .pix_ready(s_ready), .dct_ena(s_ena),
        .dct_data0(sdd[0]), .dct_data1(sdd[1]), .dct_data2(sdd[2]), .dct_data3(sdd[3]),
        .dct_data4(sdd[4]), .dct_data5(sdd[5]), .dct_data6(sdd[6]), .dct_data7(sdd[7]),
        .rows_issued(s_rows)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int sd(input int j);
        return int'($signed(dd[j]));
    endfunction

    function automatic int sdn(input int j);
        return int'($signed(ddn[j]));
    endfunction

    function automatic int ssd(input int j);
        return int'($signed(sdd[j]));
    endfunction

    // ---------------- reference model / monitor ----------------
    // Accepted pixels queue up in arrival order; each start pulse must present
    // the oldest 8 of them. Reset throws away everything not yet issued.
    int cyc = 0;
    bit pend_rst = 1'b1;
    bit pend_xfer = 1'b0;
    int pend_pix = 0;
    int q_shift[$];
    int q_raw[$];
    int ena_count = 0;
    int last_ena_cyc = -100;
    int full_wait = 0;
    int prev_d[8];
    int ena_cycs[$];

    always @(negedge clk) begin
        cyc++;
        if (pend_rst) begin
            q_shift.delete();
            q_raw.delete();
            ena_count = 0;
            full_wait = 0;
            last_ena_cyc = -100;
            check("rst_dct_ena", dct_ena, 0);
            check("rst_rows_issued", rows_issued, 0);
            for (int j = 0; j < 8; j++) begin
                check("rst_dct_data", sd(j), 0);
            end
        end else begin
            if (pend_xfer) begin
                q_shift.push_back(pend_pix - HALF);
                q_raw.push_back(pend_pix);
            end
            check("rows_issued", rows_issued, ena_count % 65536);
            check("ena_ns_match", dct_ena_ns, dct_ena);
            if (dct_ena) begin
                if (ena_count > 0 && (cyc - last_ena_cyc) < BUSY) begin
                    check("ena_spacing", cyc - last_ena_cyc, BUSY);
                end
                if (q_shift.size() < 8) begin
                    check("ena_without_full_row", q_shift.size(), 8);
                end else begin
                    for (int j = 0; j < 8; j++) begin
                        check("row_data", sd(j), q_shift.pop_front());
                        check("row_data_ns", sdn(j), q_raw.pop_front());
                    end
                end
                ena_count++;
                last_ena_cyc = cyc;
                ena_cycs.push_back(cyc);
                full_wait = 0;
                $display("row %0d issued at cycle %0d: d0=%0d d7=%0d", ena_count, cyc, sd(0), sd(7));
            end else begin
                for (int j = 0; j < 8; j++) begin
                    check("data_stable", sd(j), prev_d[j]);
                end
                if (q_shift.size() >= 8) begin
                    full_wait++;
                    if (full_wait > BUSY + 1) begin
                        check("row_wait_cycles", full_wait, BUSY + 1);
                        full_wait = 0;
                    end
                end
            end
            if (rst) begin
                check("ready_in_rst", pix_ready, 0);
            end else if (q_shift.size() < 8) begin
                check("pix_ready", pix_ready, 1);
            end
        end
        for (int j = 0; j < 8; j++) begin
            prev_d[j] = sd(j);
        end
        pend_rst  = rst;
        pend_xfer = pix_valid && pix_ready && !rst;
        pend_pix  = int'(pix_data);
    end

    // ---------------- driver helpers (called at posedge+1) ----------------
    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        pix_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_pix(input int p, output int stalls, output int xcyc);
        int n = 0;
        pix_valid = 1'b1;
        pix_data = W'(p);
        @(negedge clk);
        #1;
        while (!pix_ready && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        if (!pix_ready) check("send_timeout", 0, 1);
        stalls = n;
        xcyc = cyc;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
    endtask

    task automatic wait_rows(input int target, input int budget);
        int n = 0;
        while (ena_count < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("wait_rows", ena_count, target);
        @(posedge clk);
        #1;
    endtask

    // Two back-to-back rows into a slow DCT: the second row must stall
    // pix_ready until the copy edge, and a pixel held during the stall must
    // land as the first pixel of the third row.
    task automatic slow_test();
        int list[24];
        int pi = 0;
        int seen = 0;
        int ena_c[3];
        int rel;
        bit took;
        for (int i = 0; i < 24; i++) list[i] = 10 * (i / 8) + 10 + (i % 8);
        for (int i = 0; i < 3; i++) ena_c[i] = 0;
        s_valid = 1'b1;
        s_data = W'(list[0]);
        for (int c = 0; c < 80 && seen < 3; c++) begin
            @(negedge clk);
            #1;
            took = s_valid && s_ready;
            if (s_ena) begin
                if (seen > 0) check("slow_ena_spacing", c - ena_c[seen-1], SLOW_BUSY);
                for (int j = 0; j < 8; j++) check("slow_row_data", ssd(j), list[8*seen+j] - HALF);
                ena_c[seen] = c;
                seen++;
                $display("slow row %0d issued at cycle %0d: d0=%0d", seen, c, ssd(0));
            end else if (seen == 1) begin
                for (int j = 0; j < 8; j++) check("slow_hold", ssd(j), list[j] - HALF);
            end
            if (seen >= 1 && (c - ena_c[0]) <= 18) begin
                rel = c - ena_c[0];
                check("slow_pix_ready", s_ready, (rel >= 7 && rel <= 10) ? 0 : 1);
            end
            @(posedge clk);
            #1;
            if (took) begin
                pi++;
                if (pi < 24) s_data = W'(list[pi]);
                else s_valid = 1'b0;
            end
        end
        s_valid = 1'b0;
        check("slow_rows_seen", seen, 3);
        check("slow_rows_issued", s_rows, 3);
    endtask

    typedef struct {
        int pix[8];
        int exp[8];
        int exp_ns[8];
    } vec_t;

    vec_t tbl[NV];

    initial begin
        int st, xc, tot;
        int g;

        tbl[0].pix    = '{0, 1, 2, 3, 4, 5, 6, 7};
        tbl[0].exp    = '{-128, -127, -126, -125, -124, -123, -122, -121};
        tbl[0].exp_ns = '{0, 1, 2, 3, 4, 5, 6, 7};
        tbl[1].pix    = '{255, 255, 255, 255, 255, 255, 255, 255};
        tbl[1].exp    = '{127, 127, 127, 127, 127, 127, 127, 127};
        tbl[1].exp_ns = '{255, 255, 255, 255, 255, 255, 255, 255};
        tbl[2].pix    = '{200, 200, 200, 200, 200, 200, 200, 200};
        tbl[2].exp    = '{72, 72, 72, 72, 72, 72, 72, 72};
        tbl[2].exp_ns = '{200, 200, 200, 200, 200, 200, 200, 200};
        tbl[3].pix    = '{0, 255, 128, 127, 1, 254, 64, 192};
        tbl[3].exp    = '{-128, 127, 0, -1, -127, 126, -64, 64};
        tbl[3].exp_ns = '{0, 255, 128, 127, 1, 254, 64, 192};

        // Table rows: fresh reset, gap-free row, fixed latency and contents.
        for (int v = 0; v < NV; v++) begin
            do_reset(2);
            for (int j = 0; j < 8; j++) begin
                send_pix(tbl[v].pix[j], st, xc);
                if (j == 0) check("first_accept_after_rst", st, 0);
            end
            wait_rows(1, 20);
            check("ena_latency", last_ena_cyc - xc, 2);
            for (int j = 0; j < 8; j++) begin
                check("vec_data", sd(j), tbl[v].exp[j]);
                check("vec_data_ns", sdn(j), tbl[v].exp_ns[j]);
            end
            check("vec_rows_issued", rows_issued, 1);
            $display("vector %0d done: ena latency %0d", v, last_ena_cyc - xc);
        end

        // Continuous stream of 4 rows: no back-pressure, pulses 8 apart.
        do_reset(2);
        ena_cycs.delete();
        tot = 0;
        for (int k = 0; k < 32; k++) begin
            send_pix(255, st, xc);
            tot += st;
        end
        check("stream_stalls", tot, 0);
        wait_rows(4, 30);
        check("stream_pulses", ena_cycs.size(), 4);
        if (ena_cycs.size() == 4) begin
            for (int i = 1; i < 4; i++) check("stream_spacing", ena_cycs[i] - ena_cycs[i-1], 8);
        end
        check("stream_rows_issued", rows_issued, 4);

        // Reset mid-row discards the partial row.
        do_reset(2);
        for (int k = 0; k < 5; k++) send_pix(40 + k, st, xc);
        do_reset(1);
        for (int k = 0; k < 8; k++) send_pix(200, st, xc);
        wait_rows(1, 20);
        repeat (10) @(posedge clk);
        #1;
        check("midrow_rst_pulses", ena_count, 1);
        check("midrow_rst_rows", rows_issued, 1);
        for (int j = 0; j < 8; j++) check("midrow_rst_data", sd(j), 72);

        // Reset during BUSY leaves no pulse and a zero count.
        do_reset(2);
        for (int k = 0; k < 8; k++) send_pix(99, st, xc);
        wait_rows(1, 20);
        do_reset(1);
        repeat (15) @(posedge clk);
        #1;
        check("busy_rst_rows", rows_issued, 0);
        check("busy_rst_pulses", ena_count, 0);

        // Randomized gaps over 1000 rows against the pixel-queue model.
        do_reset(2);
        for (int r = 0; r < 1000; r++) begin
            for (int j = 0; j < 8; j++) begin
                if ($urandom_range(0, 1) == 1) begin
                    g = $urandom_range(1, 3);
                    repeat (g) begin
                        @(posedge clk);
                        #1;
                    end
                end
                send_pix($urandom_range(0, 255), st, xc);
            end
        end
        wait_rows(1000, 40);
        check("rand_rows_issued", rows_issued, 1000);
        check("rand_queue_empty", q_shift.size(), 0);

        // Slow DCT instance: stall while BUSY and copy/transfer overlap.
        do_reset(2);
        slow_test();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual timeout required finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
